// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed byte/half/word requests from the core
// into word-index accesses on a synchronous data memory with a 1-cycle read.
// Sub-word stores are done as read-modify-write and hold busy_o high while
// they run.
//
// state | meaning
// IDLE  | waiting for req_i; request checked for errors here
// RD    | memory read strobe for a load or a sub-word store
// LD    | read data valid; extract/extend lane into rdata_o
// MRG   | read data valid; replace target lane with store data
// WR    | memory write strobe with merged (or full) word
module load_store_unit #(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              done_o,
    output logic              err_o,
    output logic              busy_o,
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [2:0] {IDLE, RD, LD, MRG, WR} state_t;

    state_t            state, state_nxt;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q;
    logic              req_err;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_val;
    logic [31:0]       merge_val;

    // Misaligned, illegal-size and out-of-range requests are rejected at capture.
    always_comb begin
        req_err = 1'b0;
        case (size_i)
            2'b01:   req_err = addr_i[0];
            2'b10:   req_err = |addr_i[1:0];
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if (|addr_i[ADDR_W-1:INDEX_W+2]) req_err = 1'b1;
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and state-decoded strobes; strobes drop as soon as reset forces IDLE.
    always_comb begin
        state_nxt = state;
        mem_re_o  = 1'b0;
        mem_we_o  = 1'b0;
        busy_o    = (state != IDLE);
        case (state)
            IDLE: if (req_i && !req_err)
                      state_nxt = (we_i && size_i == 2'b10) ? WR : RD;
            RD: begin
                mem_re_o  = 1'b1;
                state_nxt = we_q ? MRG : LD;
            end
            LD:  state_nxt = IDLE;
            MRG: state_nxt = WR;
            WR: begin
                mem_we_o  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request whenever one is sampled in IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && req_i) begin
            we_q    <= we_i;
            size_q  <= size_i;
            uns_q   <= unsigned_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end
    end

    // Lane extraction for loads and lane replacement for sub-word stores (little-endian).
    always_comb begin
        byte_sel  = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        half_sel  = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_val = mem_rdata_i;
        endcase
        merge_val = mem_rdata_i;
        if (size_q == 2'b00) merge_val[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
        else                 merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    // Registered results: load data, merge word and single-cycle completion pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_o <= '0;
            done_o  <= 1'b0;
            err_o   <= 1'b0;
            merge_q <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: if (req_i && req_err) begin
                          done_o <= 1'b1;
                          err_o  <= 1'b1;
                      end
                LD: begin
                    rdata_o <= load_val;
                    done_o  <= 1'b1;
                end
                MRG: merge_q <= merge_val;
                WR:  done_o  <= 1'b1;
                default: ;
            endcase
        end
    end

    assign mem_addr_o  = busy_o ? {{(34-ADDR_W){1'b0}}, addr_q[ADDR_W-1:2]} : 32'd0;
    assign mem_wdata_o = (size_q == 2'b10) ? wdata_q : merge_q;

endmodule
